// File: rtl/i2c_codec_cfg_seq_if.sv
// rtl/i2c_codec_cfg_seq_if.sv - handshake bundle between the config sequencer and the I2C controller
//
// Signals:
//   i2c_data  24  {addr, r/w, reg, data} word offered to the controller
//   i2c_go     1  transfer request, held until i2c_end
//   i2c_end    1  transfer finished, from the controller
//   i2c_ack    3  controller ACK bits; any nonzero bit means NACK
// Modports: master = sequencer side, slave = controller side.
interface i2c_codec_cfg_seq_if;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic [2:0]  i2c_ack;

  modport master (
    output i2c_data,
    output i2c_go,
    input  i2c_end,
    input  i2c_ack
  );

  modport slave (
    input  i2c_data,
    input  i2c_go,
    output i2c_end,
    output i2c_ack
  );
endinterface

// File: rtl/i2c_codec_cfg_seq.sv
// rtl/i2c_codec_cfg_seq.sv - codec register-write sequencer with NACK retry and volume tracking
//
// Walks an external ROM of NUM_CMDS {reg[6:0], data[8:0]} words, sending each one
// through the I2C controller handshake. A NACK retries the same entry up to
// MAX_RETRY times before parking in ERR. Once init is done, a change of the
// effective volume re-sends the left and right volume entries.
//
// Ports:
//   clk_i2c   in   1  clock, all state on its rising edge
//   reset     in   1  asynchronous active-high reset
//   start     in   1  one-cycle pulse, (re)runs the init table from IDLE/DONE/ERR
//   volume    in   7  volume code, sent as data {2'b11, volume}
//   mute      in   1  only when CFG_MUTE_EN is defined; forces effective volume to 0
//   tbl_idx   out  4  ROM address
//   tbl_word  in  16  ROM data for tbl_idx, combinational
//   i2c       if      master side of i2c_codec_cfg_seq_if (data/go/end/ack)
//   busy      out  1  sequence in progress
//   done      out  1  table (or volume update) finished
//   err       out  1  retries exhausted; sticky until start or reset
//   err_idx   out  4  index of the command that failed
//
// Optional feature macro: CFG_MUTE_EN (adds the mute input).
module i2c_codec_cfg_seq #(
  parameter int         NUM_CMDS   = 9,
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter int         VOL_L_IDX  = 3,
  parameter int         VOL_R_IDX  = 4
) (
  input  logic                       clk_i2c,
  input  logic                       reset,
  input  logic                       start,
  input  logic [6:0]                 volume,
`ifdef CFG_MUTE_EN
  input  logic                       mute,
`endif
  output logic [3:0]                 tbl_idx,
  input  logic [15:0]                tbl_word,
  i2c_codec_cfg_seq_if.master        i2c,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [3:0]                 err_idx
);

  localparam logic [3:0] LAST_IDX  = 4'(NUM_CMDS - 1);
  localparam logic [3:0] VOL_L     = 4'(VOL_L_IDX);
  localparam logic [3:0] VOL_R     = 4'(VOL_R_IDX);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT, CHECK, NEXT, DONE, ERR
  } state_t;

  state_t     state;
  logic       mode_vol;   // 0: running the init table, 1: volume-only update
  logic [2:0] retry;
  logic [6:0] vol_last;
  logic [6:0] eff_vol;
  logic [8:0] data_field;

`ifdef CFG_MUTE_EN
  assign eff_vol = mute ? 7'h00 : volume;
`else
  assign eff_vol = volume;
`endif

  // Volume entries always carry the live volume, in both init and update runs.
  always_comb begin
    data_field = tbl_word[8:0];
    if (tbl_idx == VOL_L || tbl_idx == VOL_R) begin
      data_field = {2'b11, eff_vol};
    end
  end

  always_ff @(posedge clk_i2c or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mode_vol     <= 1'b0;
      retry        <= 3'd0;
      vol_last     <= 7'd0;
      tbl_idx      <= 4'd0;
      i2c.i2c_data <= 24'd0;
      i2c.i2c_go   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_idx      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tbl_idx  <= 4'd0;
            mode_vol <= 1'b0;
            retry    <= 3'd0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          i2c.i2c_data <= {SLAVE_ADDR, 1'b0, tbl_word[15:9], data_field};
          state        <= SEND;
        end

        SEND: begin
          i2c.i2c_go <= 1'b1;
          state      <= WAIT;
        end

        WAIT: begin
          if (i2c.i2c_end) begin
            i2c.i2c_go <= 1'b0;
            state      <= CHECK;
          end
        end

        CHECK: begin
          if (i2c.i2c_ack == 3'b000) begin
            retry <= 3'd0;
            state <= NEXT;
          end else if (retry < RETRY_MAX) begin
            retry <= retry + 3'd1;
            state <= LOAD;
          end else begin
            err_idx <= tbl_idx;
            err     <= 1'b1;
            busy    <= 1'b0;
            retry   <= 3'd0;
            state   <= ERR;
          end
        end

        NEXT: begin
          if (!mode_vol) begin
            if (tbl_idx < LAST_IDX) begin
              tbl_idx <= tbl_idx + 4'd1;
              state   <= LOAD;
            end else begin
              // Init already sent the current volume; arm the watcher from it.
              vol_last <= eff_vol;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end
          end else if (tbl_idx == VOL_L) begin
            tbl_idx <= VOL_R;
            state   <= LOAD;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          // start has priority over a simultaneous volume change.
          if (start) begin
            tbl_idx  <= 4'd0;
            mode_vol <= 1'b0;
            retry    <= 3'd0;
            done     <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end else if (eff_vol != vol_last) begin
            vol_last <= eff_vol;
            mode_vol <= 1'b1;
            tbl_idx  <= VOL_L;
            done     <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        ERR: begin
          i2c.i2c_go <= 1'b0;
          if (start) begin
            err      <= 1'b0;
            tbl_idx  <= 4'd0;
            mode_vol <= 1'b0;
            retry    <= 3'd0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        default: begin
          i2c.i2c_go <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_codec_cfg_seq.sv
// tb/tb_i2c_codec_cfg_seq.sv - scoreboard bench for i2c_codec_cfg_seq
module tb_i2c_codec_cfg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  volume;
`ifdef CFG_MUTE_EN
  logic        mute;
`endif
  logic [3:0]  tbl_idx;
  logic [15:0] tbl_word;
  logic        busy, done, err;
  logic [3:0]  err_idx;

  i2c_codec_cfg_seq_if bus ();

  i2c_codec_cfg_seq dut (
    .clk_i2c  (clk),
    .reset    (rst),
    .start    (start),
    .volume   (volume),
`ifdef CFG_MUTE_EN
    .mute     (mute),
`endif
    .tbl_idx  (tbl_idx),
    .tbl_word (tbl_word),
    .i2c      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_idx  (err_idx)
  );

  always #5 clk = ~clk;

  // External ROM: index 0 -> reg 0x0F, index i>0 -> reg i-1 (so 3 -> reg 2, 4 -> reg 3).
  logic [15:0] rom [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[i] = {((i == 0) ? 7'h0F : 7'(i - 1)), 9'(9'h0A0 + i * 3)};
    end
  end
  always_comb tbl_word = rom[tbl_idx];

  int n_assert = 0;
  int n_fail   = 0;
  logic [23:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_entry(input int i, input logic [6:0] v);
    logic [15:0] w;
    w = rom[i];
    return {7'h1A, 1'b0, w[15:9], ((i == 3 || i == 4) ? {2'b11, v} : w[8:0])};
  endfunction

  task automatic push_range(input int first, input int last, input logic [6:0] v);
    for (int i = first; i <= last; i++) exp_q.push_back(exp_entry(i, v));
  endtask

  // Controller model: answers each go with end after two cycles, ack from nack plan.
  int   nack_left [16];
  int   ctl_state = 0;
  int   ctl_cnt   = 0;
  logic stall     = 1'b0;
  logic [3:0] stall_idx = 4'd0;

  always @(negedge clk) begin
    if (rst) begin
      ctl_state    = 0;
      bus.i2c_end  = 1'b0;
      bus.i2c_ack  = 3'b000;
    end else begin
      case (ctl_state)
        0: if (bus.i2c_go && !(stall && tbl_idx == stall_idx)) begin
             ctl_cnt = 0;
             ctl_state = 1;
           end
        1: if (ctl_cnt == 1) begin
             bus.i2c_end = 1'b1;
             if (nack_left[tbl_idx] > 0) begin
               bus.i2c_ack = 3'b010;
               nack_left[tbl_idx]--;
             end else begin
               bus.i2c_ack = 3'b000;
             end
             ctl_state = 2;
           end else begin
             ctl_cnt++;
           end
        2: begin
             bus.i2c_end = 1'b0;   // ack stays up for the CHECK edge
             ctl_state = 3;
           end
        default: begin
             bus.i2c_ack = 3'b000;
             if (!bus.i2c_go) ctl_state = 0;
           end
      endcase
    end
  end

  // Monitor: every rising i2c_go is one transfer; compare its data with the scoreboard.
  logic go_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.i2c_go && !go_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_transfer", {8'd0, bus.i2c_data}, 32'hFFFF_FFFF);
      end else begin
        check("xfer_data", {8'd0, bus.i2c_data}, {8'd0, exp_q.pop_front()});
      end
    end
    go_prev = bus.i2c_go;
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!busy && n < 8) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; volume = 7'h79;
`ifdef CFG_MUTE_EN
    mute = 1'b0;
`endif
    for (int i = 0; i < 16; i++) nack_left[i] = 0;
    idle_cycles(3);
    check("rst_go",      {31'd0, bus.i2c_go}, 32'd0);
    check("rst_data",    {8'd0, bus.i2c_data}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    check("rst_err",     {31'd0, err}, 32'd0);
    check("rst_err_idx", {28'd0, err_idx}, 32'd0);
    check("rst_tbl_idx", {28'd0, tbl_idx}, 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Full init, volume 7'h79, and start-to-go latency of three edges.
    push_range(0, 8, 7'h79);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("lat_edge1_go",   {31'd0, bus.i2c_go}, 32'd0);
    check("lat_edge1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("lat_edge2_go", {31'd0, bus.i2c_go}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_go", {31'd0, bus.i2c_go}, 32'd1);
    wait_idle("init_timeout");
    check("init_done", {31'd0, done}, 32'd1);
    check("init_err",  {31'd0, err}, 32'd0);
    check("init_sb_empty", exp_q.size(), 32'd0);

    // Volume change in DONE: left then right volume only.
    exp_q.push_back(24'h3405D0);
    exp_q.push_back(24'h3407D0);
    @(negedge clk); volume = 7'h50;
    wait_idle("vol_timeout");
    check("vol_done", {31'd0, done}, 32'd1);
    check("vol_sb_empty", exp_q.size(), 32'd0);

`ifdef CFG_MUTE_EN
    exp_q.push_back(24'h340580);
    exp_q.push_back(24'h340780);
    @(negedge clk); mute = 1'b1;
    wait_idle("mute_timeout");
    check("mute_sb_empty", exp_q.size(), 32'd0);
    exp_q.push_back(24'h3405D0);
    exp_q.push_back(24'h3407D0);
    @(negedge clk); mute = 1'b0;
    wait_idle("unmute_timeout");
    check("unmute_sb_empty", exp_q.size(), 32'd0);
`endif

    // Start and volume change together in DONE: full init with new volume, no extra update.
    push_range(0, 8, 7'h33);
    @(negedge clk); volume = 7'h33; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle("simul_timeout");
    idle_cycles(20);
    check("simul_done", {31'd0, done}, 32'd1);
    check("simul_sb_empty", exp_q.size(), 32'd0);

    // Two NACKs on index 2, then ACK.
    nack_left[2] = 2;
    push_range(0, 2, 7'h33);
    push_range(2, 2, 7'h33);
    push_range(2, 8, 7'h33);
    pulse_start();
    wait_idle("nack_timeout");
    check("nack_done", {31'd0, done}, 32'd1);
    check("nack_err",  {31'd0, err}, 32'd0);
    check("nack_sb_empty", exp_q.size(), 32'd0);

    // Four NACKs on index 5: retries exhausted.
    nack_left[5] = 4;
    push_range(0, 5, 7'h33);
    for (int k = 0; k < 3; k++) push_range(5, 5, 7'h33);
    pulse_start();
    wait_idle("err_timeout");
    check("err_flag", {31'd0, err}, 32'd1);
    check("err_idx",  {28'd0, err_idx}, 32'd5);
    check("err_go",   {31'd0, bus.i2c_go}, 32'd0);
    check("err_done", {31'd0, done}, 32'd0);
    check("err_sb_empty", exp_q.size(), 32'd0);
    @(negedge clk); volume = 7'h11;   // watcher must stay inactive in ERR
    idle_cycles(20);
    check("err_sticky", {31'd0, err}, 32'd1);
    push_range(0, 8, 7'h11);
    pulse_start();
    wait_idle("rerun_timeout");
    check("rerun_err",  {31'd0, err}, 32'd0);
    check("rerun_done", {31'd0, done}, 32'd1);
    check("rerun_sb_empty", exp_q.size(), 32'd0);

    // Reset while waiting on index 4.
    stall = 1'b1; stall_idx = 4'd4;
    push_range(0, 4, 7'h11);
    pulse_start();
    begin
      int n;
      n = 0;
      while (!(tbl_idx == 4'd4 && bus.i2c_go) && n < 500) begin @(negedge clk); n++; end
      check("stall_reached", {31'd0, bus.i2c_go}, 32'd1);
    end
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("arst_go",   {31'd0, bus.i2c_go}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    stall = 1'b0;
    idle_cycles(20);
    check("arst_idle_busy", {31'd0, busy}, 32'd0);
    check("arst_sb_empty", exp_q.size(), 32'd0);
    push_range(0, 8, 7'h11);
    pulse_start();
    wait_idle("post_rst_timeout");
    check("post_rst_done", {31'd0, done}, 32'd1);

    idle_cycles(5);
    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
